// File: rtl/exc_sequencer_if.sv
// Pipeline/CP0 side bundle for the exception sequencer.
interface exc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  // M-stage status from the pipeline
  logic              m_valid;
  logic [31:0]       m_pc;
  logic              m_bd;
  logic              m_is_branch;
  logic              m_eret;
  logic              m_stall;
  // CP0 responses
  logic              cp0_req;
  logic [31:0]       cp0_epc;
  // CP0 drive
  logic [31:0]       cp0_vpc;
  logic              cp0_bd;
  logic              cp0_exlclr;
  // Pipeline control
  logic              flush_all;
  logic              flush_young;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  trap_count;

  // Sequencer side
  modport slave (
    input  m_valid, m_pc, m_bd, m_is_branch, m_eret, m_stall,
    input  cp0_req, cp0_epc,
    output cp0_vpc, cp0_bd, cp0_exlclr,
    output flush_all, flush_young, redirect_valid, redirect_pc, trap_count
  );

  // Pipeline/CP0 side
  modport master (
    output m_valid, m_pc, m_bd, m_is_branch, m_eret, m_stall,
    output cp0_req, cp0_epc,
    input  cp0_vpc, cp0_bd, cp0_exlclr,
    input  flush_all, flush_young, redirect_valid, redirect_pc, trap_count
  );
endinterface

// File: rtl/exc_sequencer.sv
// Exception entry / eret exit sequencer sitting between the M stage and CP0.
// Presents the victim PC to CP0, converts CP0 requests into flush+redirect,
// and masks CP0 for a few cycles after every redirect.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter int unsigned MASK_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  exc_sequencer_if.slave bus
);

  localparam logic [3:0]       MASK_INIT = 4'(MASK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MASK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic             shadow_q, shadow_d;
  logic [3:0]       mask_cnt_q, mask_cnt_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;

  logic [31:0]      cp0_vpc_c;
  logic             cp0_bd_c;
  logic             cp0_exlclr_c;
  logic             flush_all_c;
  logic             flush_young_c;
  logic             redirect_valid_c;
  logic [31:0]      redirect_pc_c;

  logic             eret_go;

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_MASK;
      next_pc_q    <= HANDLER_PC;
      shadow_q     <= 1'b0;
      mask_cnt_q   <= MASK_INIT;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      next_pc_q    <= next_pc_d;
      shadow_q     <= shadow_d;
      mask_cnt_q   <= mask_cnt_d;
      trap_count_q <= trap_count_d;
    end
  end

  // Eret only fires when M can actually retire it
  assign eret_go = bus.m_valid & bus.m_eret & ~bus.m_stall;

  // Next-state, victim-PC select and redirect decisions
  always_comb begin
    state_d          = state_q;
    next_pc_d        = next_pc_q;
    shadow_d         = shadow_q;
    mask_cnt_d       = mask_cnt_q;
    trap_count_d     = trap_count_q;
    cp0_vpc_c        = 32'h0;
    cp0_bd_c         = 1'b0;
    cp0_exlclr_c     = 1'b0;
    flush_all_c      = 1'b0;
    flush_young_c    = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = HANDLER_PC;

    if (state_q == ST_RUN) begin
      // Victim PC: real instruction, else the resume PC unless in a branch shadow
      if (bus.m_valid) begin
        cp0_vpc_c = bus.m_pc;
        cp0_bd_c  = bus.m_bd;
      end else if (!shadow_q) begin
        cp0_vpc_c = next_pc_q;
      end

      if (bus.cp0_req) begin
        // Exception entry outranks eret and stall
        flush_all_c      = 1'b1;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = HANDLER_PC;
        state_d          = ST_MASK;
        mask_cnt_d       = MASK_INIT;
        next_pc_d        = HANDLER_PC;
        shadow_d         = 1'b0;
        trap_count_d     = (trap_count_q == CNT_MAX) ? trap_count_q
                                                     : trap_count_q + CNT_ONE;
      end else if (eret_go) begin
        // Eret keeps itself in M and returns to EPC
        cp0_exlclr_c     = 1'b1;
        flush_young_c    = 1'b1;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = bus.cp0_epc;
        state_d          = ST_MASK;
        mask_cnt_d       = MASK_INIT;
        next_pc_d        = bus.cp0_epc;
        shadow_d         = 1'b0;
      end else if (bus.m_valid && !bus.m_stall) begin
        // Track the resume PC; a branch defers bubble interrupts to its delay slot
        next_pc_d = bus.m_pc + 32'd4;
        shadow_d  = bus.m_is_branch;
      end
    end else begin
      // Masked window: CP0 sees no instruction, requests are ignored
      mask_cnt_d = mask_cnt_q - 4'd1;
      if (mask_cnt_q <= 4'd1) begin
        state_d = ST_RUN;
      end
    end
  end

  assign bus.cp0_vpc        = cp0_vpc_c;
  assign bus.cp0_bd         = cp0_bd_c;
  assign bus.cp0_exlclr     = cp0_exlclr_c;
  assign bus.flush_all      = flush_all_c;
  assign bus.flush_young    = flush_young_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.trap_count     = trap_count_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: directed per-cycle vectors push their
// expected outputs, monitors on the falling edge pop and compare.
module tb_exc_sequencer;

  localparam logic [31:0] H = 32'h0000_4180;

  logic clk;
  logic reset_a;
  logic reset_b;

  int total;
  int bad;
  int step_a;
  int step_b;

  exc_sequencer_if #(.CNT_W(16)) bus_a ();
  exc_sequencer_if #(.CNT_W(3))  bus_b ();

  exc_sequencer #(.HANDLER_PC(H), .MASK_CYCLES(1), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  exc_sequencer #(.HANDLER_PC(H), .MASK_CYCLES(3), .CNT_W(3)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  typedef struct {
    int          step;
    logic [31:0] vpc;
    logic        bd;
    logic        exl;
    logic        fa;
    logic        fy;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] tc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, step, act, want);
    end
  endtask

  // One cycle on DUT A plus its expected outputs
  task automatic va(input logic v, input logic [31:0] pc, input logic bd,
                    input logic br, input logic er, input logic st,
                    input logic rq, input logic [31:0] epc,
                    input logic [31:0] e_vpc, input logic e_bd,
                    input logic e_exl, input logic e_fa, input logic e_fy,
                    input logic e_rv, input logic [31:0] e_rpc,
                    input logic [31:0] e_tc);
    exp_t e;
    @(posedge clk);
    #1;
    reset_a             = 1'b0;
    bus_a.m_valid       = v;
    bus_a.m_pc          = pc;
    bus_a.m_bd          = bd;
    bus_a.m_is_branch   = br;
    bus_a.m_eret        = er;
    bus_a.m_stall       = st;
    bus_a.cp0_req       = rq;
    bus_a.cp0_epc       = epc;
    e.step = step_a; e.vpc = e_vpc; e.bd = e_bd; e.exl = e_exl;
    e.fa = e_fa; e.fy = e_fy; e.rv = e_rv; e.rpc = e_rpc; e.tc = e_tc;
    qa.push_back(e);
    step_a++;
  endtask

  // One cycle on DUT B (victim PC and trap counter only)
  task automatic vb(input logic rst, input logic rq, input logic [31:0] e_vpc,
                    input logic [31:0] e_tc);
    exp_t e;
    @(posedge clk);
    #1;
    reset_b       = rst;
    bus_b.cp0_req = rq;
    e.step = step_b; e.vpc = e_vpc; e.tc = e_tc;
    e.bd = 1'b0; e.exl = 1'b0; e.fa = 1'b0; e.fy = 1'b0; e.rv = 1'b0; e.rpc = H;
    qb.push_back(e);
    step_b++;
  endtask

  task automatic idle_a(input logic rq, input logic [31:0] e_vpc,
                        input logic [31:0] e_tc);
    va(0, 32'h0, 0, 0, 0, 0, rq, 32'h0, e_vpc, 0, 0, 0, 0, 0, H, e_tc);
  endtask

  // Monitor A: compare every output field
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_vpc",   e.step, bus_a.cp0_vpc, e.vpc);
        chk("a_bd",    e.step, 32'(bus_a.cp0_bd), 32'(e.bd));
        chk("a_exl",   e.step, 32'(bus_a.cp0_exlclr), 32'(e.exl));
        chk("a_fall",  e.step, 32'(bus_a.flush_all), 32'(e.fa));
        chk("a_fyng",  e.step, 32'(bus_a.flush_young), 32'(e.fy));
        chk("a_rv",    e.step, 32'(bus_a.redirect_valid), 32'(e.rv));
        chk("a_rpc",   e.step, bus_a.redirect_pc, e.rpc);
        chk("a_tc",    e.step, 32'(bus_a.trap_count), e.tc);
      end
    end
  end

  // Monitor B: mask length, saturation and reset reload
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_vpc", e.step, bus_b.cp0_vpc, e.vpc);
        chk("b_tc",  e.step, 32'(bus_b.trap_count), e.tc);
        chk("b_rv",  e.step, 32'(bus_b.redirect_valid), 32'(bus_b.cp0_req & (e.vpc != 32'h0)));
      end
    end
  end

  initial begin
    total = 0; bad = 0; step_a = 0; step_b = 0;
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.m_valid = 0; bus_a.m_pc = 0; bus_a.m_bd = 0; bus_a.m_is_branch = 0;
    bus_a.m_eret = 0; bus_a.m_stall = 0; bus_a.cp0_req = 0; bus_a.cp0_epc = 0;
    bus_b.m_valid = 1; bus_b.m_pc = 32'h100; bus_b.m_bd = 0; bus_b.m_is_branch = 0;
    bus_b.m_eret = 0; bus_b.m_stall = 0; bus_b.cp0_req = 0; bus_b.cp0_epc = 0;
    repeat (2) @(posedge clk);

    // DUT A: reset, exception, branch shadow, eret, priority, stall
    idle_a(0, 32'h0, 0);                                                   // MASK after reset
    idle_a(0, H, 0);                                                       // RUN bubble -> next_pc
    va(1, 32'h3000, 0, 0, 0, 0, 1, 0, 32'h3000, 0, 0, 1, 0, 1, H, 0);      // exception
    idle_a(0, 32'h0, 1);
    idle_a(0, H, 1);
    va(1, 32'h3010, 0, 1, 0, 0, 0, 0, 32'h3010, 0, 0, 0, 0, 0, H, 1);      // branch
    idle_a(0, 32'h0, 1);                                                   // shadow bubble
    va(1, 32'h3014, 1, 0, 0, 0, 0, 0, 32'h3014, 1, 0, 0, 0, 0, H, 1);      // delay slot
    idle_a(0, 32'h3018, 1);
    va(1, 32'h301c, 0, 0, 1, 0, 0, 32'h3020,
       32'h301c, 0, 1, 0, 1, 1, 32'h3020, 1);                              // eret
    idle_a(0, 32'h0, 1);
    idle_a(0, 32'h3020, 1);
    idle_a(0, 32'h3020, 1);
    va(1, 32'h3020, 0, 0, 1, 1, 0, 32'h5000, 32'h3020, 0, 0, 0, 0, 0, H, 1); // stalled eret
    va(1, 32'h3020, 0, 0, 1, 1, 0, 32'h5000, 32'h3020, 0, 0, 0, 0, 0, H, 1);
    va(1, 32'h3020, 0, 0, 1, 0, 0, 32'h5000,
       32'h3020, 0, 1, 0, 1, 1, 32'h5000, 1);                              // stall drops
    idle_a(1, 32'h0, 1);                                                   // req ignored in MASK
    idle_a(0, 32'h5000, 1);
    va(1, 32'h5000, 0, 0, 1, 0, 1, 32'h6000, 32'h5000, 0, 0, 1, 0, 1, H, 1); // req beats eret
    idle_a(0, 32'h0, 2);
    idle_a(0, H, 2);
    va(1, H, 0, 0, 0, 1, 1, 0, H, 0, 0, 1, 0, 1, H, 2);                     // req beats stall
    idle_a(0, 32'h0, 3);
    va(1, 32'hffff_fff8, 0, 1, 0, 1, 0, 0, 32'hffff_fff8, 0, 0, 0, 0, 0, H, 3); // stalled branch
    idle_a(0, H, 3);                                                       // regs held
    va(1, 32'h7ffc, 0, 0, 0, 0, 0, 0, 32'h7ffc, 0, 0, 0, 0, 0, H, 3);
    idle_a(0, 32'h8000, 3);

    // DUT B: 3-cycle mask window, counter saturation, reset during MASK
    vb(0, 0, 32'h0, 0);
    vb(0, 0, 32'h0, 0);
    vb(0, 0, 32'h0, 0);
    for (int k = 1; k <= 8; k++) begin
      vb(0, 1, 32'h100, (k - 1 > 7) ? 7 : k - 1);
      for (int j = 0; j < 3; j++) vb(0, 0, 32'h0, (k > 7) ? 7 : k);
    end
    vb(0, 1, 32'h100, 7);                                                  // saturated trap
    vb(0, 0, 32'h0, 7);
    vb(1, 0, 32'h0, 7);                                                    // reset mid-MASK
    vb(0, 0, 32'h0, 0);
    vb(0, 0, 32'h0, 0);
    vb(0, 0, 32'h0, 0);
    vb(0, 0, 32'h100, 0);

    // Drain, bounded
    for (int i = 0; i < 4 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", qa.size() + qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
